btn_event: RTL and testbench

Classifies a debounced push-button level into single-cycle event pulses: press, short release, long press and auto-repeat. Sits directly downstream of the button debounce stage in the alarm-clock front end, on the same 1 kHz clock, and drives the time/alarm setting logic. One instance is used per button.

---
 rtl/btn_event.sv | 154 +++++++++++++++
 tb/tb_btn_event.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/btn_event.sv
// btn_event: turns a debounced push-button level into one-cycle event pulses.
//
// Optional feature macro: BTN_REPEAT_EN. When it is defined, pulses are
// generated periodically while the button is held. When it is undefined,
// repeat_pulse is tied low and the hold counter stops in HELD.
//
// Parameters
//   LONG_MS   : hold cycles, counted from the press pulse, before long_press (>= 2)
//   REPEAT_MS : cycles between auto-repeat pulses while held (>= 1)
//   CNT_W     : hold counter width, 2**CNT_W > max(LONG_MS, REPEAT_MS)
//
// Ports
//   clk_1khz      in  sole clock, rising edge
//   rst_n         in  asynchronous active-low reset
//   btn_in        in  debounced button level, active high
//   press         out one-cycle pulse on an accepted rising edge of btn_in
//   short_release out one-cycle pulse on release before long_press fired
//   long_press    out one-cycle pulse after LONG_MS cycles of continuous hold
//   repeat_pulse  out auto-repeat pulse while held ("repeat" is a reserved word)
//   held          out level, high while the FSM is in HELD
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | button released, or still held from before reset
// PRESSED | press accepted, counting towards long_press
// HELD    | long_press issued, button still down, optional auto-repeat

module btn_event #(
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int CNT_W     = 11
) (
    input  logic clk_1khz,
    input  logic rst_n,
    input  logic btn_in,
    output logic press,
    output logic short_release,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_MS);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    // Elaboration-time parameter sanity checks.
    generate
        if (LONG_MS < 2) begin : g_chk_long
            $error("btn_event: LONG_MS must be >= 2");
        end
        if (REPEAT_MS < 1) begin : g_chk_rep
            $error("btn_event: REPEAT_MS must be >= 1");
        end
        if ((64'd1 << CNT_W) <= 64'(LONG_MS)) begin : g_chk_w_long
            $error("btn_event: CNT_W too small for LONG_MS");
        end
`ifdef BTN_REPEAT_EN
        if ((64'd1 << CNT_W) <= 64'(REPEAT_MS)) begin : g_chk_w_rep
            $error("btn_event: CNT_W too small for REPEAT_MS");
        end
`endif
    endgenerate

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             btn_prev;
    logic             press_nx, short_release_nx, long_press_nx, repeat_nx;

    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            // Starting at 1 means a button held through reset must be
            // released before it can generate a press.
            btn_prev      <= 1'b1;
            press         <= 1'b0;
            short_release <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            btn_prev      <= btn_in;
            press         <= press_nx;
            short_release <= short_release_nx;
            long_press    <= long_press_nx;
            repeat_pulse  <= repeat_nx;
            held          <= (state_nx == HELD);
        end
    end

    always_comb begin
        state_nx         = state;
        cnt_nx           = cnt;
        press_nx         = 1'b0;
        short_release_nx = 1'b0;
        long_press_nx    = 1'b0;
        repeat_nx        = 1'b0;

        case (state)
            IDLE: begin
                if (btn_in && !btn_prev) begin
                    press_nx = 1'b1;
                    cnt_nx   = ONE_CNT;
                    state_nx = PRESSED;
                end
            end

            PRESSED: begin
                // Release wins over a same-edge count match.
                if (!btn_in) begin
                    short_release_nx = 1'b1;
                    state_nx         = IDLE;
                end else if (cnt == LONG_CNT) begin
                    long_press_nx = 1'b1;
                    cnt_nx        = ONE_CNT;
                    state_nx      = HELD;
                end else begin
                    cnt_nx = cnt + ONE_CNT;
                end
            end

            HELD: begin
                if (!btn_in) begin
                    state_nx = IDLE;
                end else begin
`ifdef BTN_REPEAT_EN
                    if (cnt == CNT_W'(REPEAT_MS)) begin
                        repeat_nx = 1'b1;
                        cnt_nx    = ONE_CNT;
                    end else begin
                        cnt_nx = cnt + ONE_CNT;
                    end
`else
                    cnt_nx = cnt;
`endif
                end
            end

            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_event.sv
// Scoreboard bench for btn_event with LONG_MS=10, REPEAT_MS=4.
// Stimulus pushes expected (event, edge) pairs; a negedge monitor pops one
// entry per observed pulse or held transition and compares.
// Event codes: 0 press, 1 short_release, 2 long_press, 3 repeat,
//              4 held rise, 5 held fall.

module tb_btn_event;

    localparam int L = 10;
    localparam int R = 4;

    typedef struct {
        int code;
        int edge_no;
    } exp_t;

    logic clk_1khz = 1'b0;
    logic rst_n    = 1'b1;
    logic btn_in   = 1'b0;
    logic press, short_release, long_press, repeat_pulse, held;

    int   edge_n = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    exp_t exp_q[$];
    logic held_prev = 1'b0;

    btn_event #(.LONG_MS(L), .REPEAT_MS(R), .CNT_W(11)) dut (
        .clk_1khz     (clk_1khz),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .press        (press),
        .short_release(short_release),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    always #5 clk_1khz = ~clk_1khz;

    always @(posedge clk_1khz) edge_n <= edge_n + 1;

    function automatic string ev_name(input int c);
        case (c)
            0: return "press";
            1: return "short_release";
            2: return "long_press";
            3: return "repeat";
            4: return "held_rise";
            5: return "held_fall";
            default: return "unknown";
        endcase
    endfunction

    task automatic push(input int c, input int e);
        exp_t x;
        x.code    = c;
        x.edge_no = e;
        exp_q.push_back(x);
    endtask

    // Monitor: compares every observed event against the scoreboard head.
    always @(negedge clk_1khz) begin
        logic [5:0] ev;
        exp_t       x;
        if (!rst_n) begin
            held_prev = 1'b0;
        end else begin
            ev = {held_prev && !held, !held_prev && held, repeat_pulse,
                  long_press, short_release, press};
            for (int i = 0; i < 6; i++) begin
                if (ev[i]) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_event: got %s at edge %0d, expected none",
                                 ev_name(i), edge_n);
                    end else begin
                        x = exp_q.pop_front();
                        if (x.code != i || x.edge_no != edge_n) begin
                            n_bad++;
                            $display("FAIL event_order: got %s at edge %0d, expected %s at edge %0d",
                                     ev_name(i), edge_n, ev_name(x.code), x.edge_no);
                        end
                    end
                end
            end
            held_prev = held;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk_1khz);
            #2;
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_cmp++;
        if ({press, short_release, long_press, repeat_pulse, held} != 5'b0) begin
            n_bad++;
            $display("FAIL %s: outputs p/s/l/r/h = %b, expected 00000", name,
                     {press, short_release, long_press, repeat_pulse, held});
        end
    endtask

    // Press for n sampled edges (k .. k+n-1), release sampled at k+n, then
    // stay released for gap edges. Expected events pushed before driving.
    task automatic hold_press(input int n, input int gap);
        int k;
        k = edge_n + 1;
        push(0, k);
        if (n <= L) begin
            push(1, k + n);
        end else begin
            push(2, k + L);
            push(4, k + L);
`ifdef BTN_REPEAT_EN
            for (int t = k + L + R; t < k + n; t += R) push(3, t);
`endif
            push(5, k + n);
        end
        btn_in = 1'b1;
        wait_cycles(n);
        btn_in = 1'b0;
        wait_cycles(gap);
    endtask

    initial begin
        int k;
        // Reset with the button already down.
        btn_in = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("reset_state");
        wait_cycles(3);
        check_outputs_zero("reset_held_low");
        rst_n = 1'b1;
        // Held through reset: no events for 2000 cycles.
        wait_cycles(2000);
        check_outputs_zero("held_through_reset");
        btn_in = 1'b0;
        wait_cycles(1);
        hold_press(4, 3);     // first real press after reset

        hold_press(5, 4);     // short tap
        hold_press(10, 3);    // release at k+LONG: short_release only
        hold_press(11, 3);    // release at k+LONG+1: long_press then held fall
        hold_press(31, 3);    // auto-repeat at k+14..k+30 when enabled
        hold_press(11, 1);    // release then immediate re-press
        hold_press(3, 2);
        hold_press(1, 2);     // minimum-length press

        // Reset while in HELD.
        k = edge_n + 1;
        push(0, k);
        push(2, k + L);
        push(4, k + L);
        btn_in = 1'b1;
        wait_cycles(L + 2);   // last sampled edge is k+L+1, before any repeat
        n_cmp++;
        if (held !== 1'b1) begin
            n_bad++;
            $display("FAIL held_before_reset: held = %b, expected 1", held);
        end
        rst_n = 1'b0;
        #1 check_outputs_zero("reset_mid_hold");
        wait_cycles(1);
        rst_n = 1'b1;
        wait_cycles(20);      // still held: nothing may fire
        btn_in = 1'b0;
        wait_cycles(2);
        hold_press(4, 3);     // normal timing after re-press

        wait_cycles(5);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events: %0d expected events never seen, first %s at edge %0d",
                     exp_q.size(), ev_name(exp_q[0].code), exp_q[0].edge_no);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
